regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard in front of the 32-entry register array. It shares the array's single write port (G data bus plus one-hot R_in enables) between two requesters: the ALU result path and the memory load-return path. It tracks destination registers with outstanding loads and stalls hazardous writes and issues, so each register is written in program-safe order.

---
 rtl/regfile_wb_arbiter_if.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Write-back bus between the ALU/load-return requesters, the
//               load issue path and the register-array write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  // ALU write-back request
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN:0]   alu_data;
  logic            alu_ready;
  // Load-return write-back request
  logic            mem_valid;
  logic [4:0]      mem_rd;
  logic [XLEN:0]   mem_data;
  logic            mem_ready;
  // Load issue
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            issue_ready;
  // Register-array write port and scoreboard view
  logic [XLEN:0]   G;
  logic [NREG-1:0] R_in;
  logic [NREG-1:0] busy;

  // Requester / observer side
  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output issue_valid, issue_rd,
    input  alu_ready, mem_ready, issue_ready,
    input  G, R_in, busy
  );

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  issue_valid, issue_rd,
    output alu_ready, mem_ready, issue_ready,
    output G, R_in, busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the register array's single write port between the ALU
//               and load-return paths, with a bounded-starvation ALU override
//               and a load scoreboard that blocks WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int MAX_WAIT = 4
) (
  input  wire logic           clk,
  input  wire logic           resetn,
  regfile_wb_arbiter_if.slave wb
);

  localparam int                  c_WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = c_WAIT_W'(MAX_WAIT);

  logic [XLEN:0]       r_g;
  logic [NREG-1:0]     r_r_in;
  logic [NREG-1:0]     r_busy;
  logic [c_WAIT_W-1:0] r_wait_cnt;

  // One-hot decodes of each rd field; r0 never decodes so it is neither
  // written nor tracked.
  logic [NREG-1:0] w_alu_oh;
  logic [NREG-1:0] w_mem_oh;
  logic [NREG-1:0] w_iss_oh;

  for (genvar i = 0; i < NREG; i++) begin : g_onehot
    if (i == 0) begin : g_r0
      assign w_alu_oh[i] = 1'b0;
      assign w_mem_oh[i] = 1'b0;
      assign w_iss_oh[i] = 1'b0;
    end else begin : g_rn
      assign w_alu_oh[i] = (wb.alu_rd   == 5'(i));
      assign w_mem_oh[i] = (wb.mem_rd   == 5'(i));
      assign w_iss_oh[i] = (wb.issue_rd == 5'(i));
    end
  end

  logic            w_alu_elig;
  logic            w_alu_force;
  logic            w_alu_win;
  logic            w_mem_win;
  logic            w_iss_ok;
  logic [NREG-1:0] w_mem_clr;
  logic [NREG-1:0] w_iss_set;

  // An ALU write to a register with an outstanding load would be overwritten
  // out of order by the load return, so it waits.
  assign w_alu_elig  = wb.alu_valid && !(|(w_alu_oh & r_busy));
  assign w_alu_force = w_alu_elig && (r_wait_cnt == c_WAIT_MAX);
  assign w_mem_win   = wb.mem_valid && !w_alu_force;
  assign w_alu_win   = w_alu_elig && (!wb.mem_valid || w_alu_force);
  assign w_iss_ok    = !(|(w_iss_oh & r_busy));

  // Readies are suppressed while reset is asserted so nothing looks accepted.
  assign wb.alu_ready   = resetn && w_alu_win;
  assign wb.mem_ready   = resetn && w_mem_win;
  assign wb.issue_ready = resetn && w_iss_ok;

  assign w_mem_clr = w_mem_win ? w_mem_oh : '0;
  assign w_iss_set = (wb.issue_valid && w_iss_ok) ? w_iss_oh : '0;

  // Starvation counter: counts consecutive cycles the ALU could write but lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt <= '0;
    end else if (w_alu_win || !w_alu_elig) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Register the winning write onto the array port; G holds when idle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_g    <= '0;
      r_r_in <= '0;
    end else if (w_alu_win) begin
      r_g    <= wb.alu_data;
      r_r_in <= w_alu_oh;
    end else if (w_mem_win) begin
      r_g    <= wb.mem_data;
      r_r_in <= w_mem_oh;
    end else begin
      r_r_in <= '0;
    end
  end

  // Scoreboard update; a set from a new issue overrides a same-cycle clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy & ~w_mem_clr) | w_iss_set;
    end
  end

  assign wb.G    = r_g;
  assign wb.R_in = r_r_in;
  assign wb.busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed and randomized bench for regfile_wb_arbiter against
//               a cycle-level behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int NREG     = 32;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic resetn;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .NREG(NREG)) ifc ();

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG), .MAX_WAIT(MAX_WAIT)) dut (
    .clk    (clk),
    .resetn (resetn),
    .wb     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state: what the array port and scoreboard should show,
  // and how many consecutive cycles the ALU has been passed over.
  logic [XLEN:0] m_g;
  bit   [31:0]   m_rin;
  bit   [31:0]   m_busy;
  int            m_losses;

  bit obs_ar, obs_mr, obs_ir;

  function automatic bit [31:0] onehot(input bit [4:0] rd);
    return (rd == 0) ? 32'h0 : (32'h1 << rd);
  endfunction

  task automatic model_reset();
    m_g = '0; m_rin = '0; m_busy = '0; m_losses = 0;
  endtask

  task automatic drive(input bit av, input bit [4:0] ard, input logic [XLEN:0] ad,
                       input bit mv, input bit [4:0] mrd, input logic [XLEN:0] md,
                       input bit iv, input bit [4:0] ird);
    ifc.alu_valid = av; ifc.alu_rd = ard; ifc.alu_data = ad;
    ifc.mem_valid = mv; ifc.mem_rd = mrd; ifc.mem_data = md;
    ifc.issue_valid = iv; ifc.issue_rd = ird;
  endtask

  // One clock cycle: present inputs, check everything mid-cycle against the
  // model, then let the edge happen and advance the model.
  task automatic step(input bit av, input bit [4:0] ard, input logic [XLEN:0] ad,
                      input bit mv, input bit [4:0] mrd, input logic [XLEN:0] md,
                      input bit iv, input bit [4:0] ird);
    bit alu_can, alu_wins, mem_wins, iss_ok;
    drive(av, ard, ad, mv, mrd, md, iv, ird);
    alu_can  = av && !(ard != 0 && m_busy[ard]);
    alu_wins = alu_can && (!mv || m_losses >= MAX_WAIT);
    mem_wins = mv && !alu_wins;
    iss_ok   = !(ird != 0 && m_busy[ird]);
    @(negedge clk);
    obs_ar = ifc.alu_ready; obs_mr = ifc.mem_ready; obs_ir = ifc.issue_ready;
    check("alu_ready",   64'(ifc.alu_ready),   64'(alu_wins));
    check("mem_ready",   64'(ifc.mem_ready),   64'(mem_wins));
    check("issue_ready", 64'(ifc.issue_ready), 64'(iss_ok));
    check("G",           64'(ifc.G),           64'(m_g));
    check("R_in",        64'(ifc.R_in),        64'(m_rin));
    check("busy",        64'(ifc.busy),        64'(m_busy));
    @(posedge clk);
    if (alu_wins)      begin m_g = ad; m_rin = onehot(ard); end
    else if (mem_wins) begin m_g = md; m_rin = onehot(mrd); end
    else               m_rin = '0;
    if (alu_can && !alu_wins) m_losses = (m_losses < MAX_WAIT) ? m_losses + 1 : MAX_WAIT;
    else                      m_losses = 0;
    if (mem_wins && mrd != 0)     m_busy[mrd] = 1'b0;
    if (iv && iss_ok && ird != 0) m_busy[ird] = 1'b1;
    #1;
  endtask

  task automatic idle();
    step(0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    model_reset();
    // Reset held with every requester active
    resetn = 1'b0;
    drive(1, 5'd3, 33'h1_0000_0001, 1, 5'd4, 33'h0_1234_5678, 1, 5'd6);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_alu_ready",   64'(ifc.alu_ready),   64'd0);
    check("rst_mem_ready",   64'(ifc.mem_ready),   64'd0);
    check("rst_issue_ready", 64'(ifc.issue_ready), 64'd0);
    check("rst_G",           64'(ifc.G),           64'd0);
    check("rst_R_in",        64'(ifc.R_in),        64'd0);
    check("rst_busy",        64'(ifc.busy),        64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle();

    // Single ALU write to r5
    step(1, 5'd5, 33'h0_DEADBEEF, 0, 0, '0, 0, 0);
    check("alu5_accept", 64'(obs_ar), 64'd1);
    check("alu5_R_in",   64'(ifc.R_in), 64'h20);
    check("alu5_G",      64'(ifc.G),    64'h0DEADBEEF);
    idle();
    check("alu5_R_in_clr", 64'(ifc.R_in), 64'h0);

    // Contention: ALU forced through on every fifth cycle
    for (int i = 0; i < 10; i++) begin
      step(1, 5'd1, 33'(i), 1, 5'd2, 33'(100 + i), 0, 0);
      check("fair_alu_win", 64'(obs_ar), 64'((i % 5) == 4));
    end
    idle();

    // Scoreboard WAW hazard on r7
    step(0, 0, '0, 0, 0, '0, 1, 5'd7);
    check("haz_busy7_set", 64'(ifc.busy[7]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(1, 5'd7, 33'h0_AAAA0000, 0, 0, '0, 0, 0);
      check("haz_alu_stall", 64'(obs_ar), 64'd0);
    end
    step(1, 5'd7, 33'h0_AAAA0000, 1, 5'd7, 33'h1_5555_5555, 0, 0);
    check("haz_busy7_clr", 64'(ifc.busy[7]), 64'd0);
    check("haz_R_in",      64'(ifc.R_in),    64'h80);
    step(1, 5'd7, 33'h0_AAAA0000, 0, 0, '0, 0, 0);
    check("haz_alu_go", 64'(obs_ar), 64'd1);
    idle();

    // Set/clear collision across different registers
    step(0, 0, '0, 0, 0, '0, 1, 5'd9);
    step(0, 0, '0, 1, 5'd9, 33'h0_99, 1, 5'd3);
    check("col_busy9", 64'(ifc.busy[9]), 64'd0);
    check("col_busy3", 64'(ifc.busy[3]), 64'd1);
    step(0, 0, '0, 0, 0, '0, 1, 5'd3);
    check("col_reissue_stall", 64'(obs_ir), 64'd0);
    step(0, 0, '0, 1, 5'd3, 33'h0_33, 0, 0);
    idle();

    // Write to r0 is accepted but never enables the array
    step(1, 5'd0, 33'h1_FFFF_FFFF, 0, 0, '0, 0, 0);
    check("r0_accept", 64'(obs_ar), 64'd1);
    check("r0_R_in",   64'(ifc.R_in), 64'h0);
    idle();

    // Reset asserted while an accepted write is about to land
    step(0, 0, '0, 0, 0, '0, 1, 5'd6);
    drive(1, 5'd4, 33'h0_CAFE, 0, 0, '0, 0, 0);
    @(negedge clk);
    check("mr_pre_accept", 64'(ifc.alu_ready), 64'd1);
    resetn = 1'b0;
    #1;
    check("mr_busy_async", 64'(ifc.busy), 64'h0);
    @(posedge clk); #1;
    check("mr_R_in", 64'(ifc.R_in), 64'h0);
    check("mr_G",    64'(ifc.G),    64'h0);
    model_reset();
    resetn = 1'b1;
    idle();

    // Randomized traffic over a small register window to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, 5'($urandom_range(0, 7)), {1'($urandom), 32'($urandom)},
           ($urandom % 2) != 0, 5'($urandom_range(0, 7)), {1'($urandom), 32'($urandom)},
           ($urandom % 5) < 2,  5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
